// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - streams bytes into a single-port RAM, then reads the region back and verifies an additive checksum
module ram_loader #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int START_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_length,
    input  logic [DATA_W-1:0] i_s_data,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [DATA_W-1:0] o_checksum
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   idx;
    logic [DATA_W-1:0] rsum;

    logic [ADDR_W:0]   len_clamped;
    logic              last;
    logic [DATA_W-1:0] rsum_next;

    assign len_clamped = (i_length > MAX_LEN) ? MAX_LEN : i_length;
    assign last        = (idx == len_q - ONE);
    assign rsum_next   = rsum + i_mem_data;

    // o_s_ready is high exactly in LOAD, so it doubles as the write window
    assign o_mem_addr = BASE + idx[ADDR_W-1:0];
    assign o_mem_we   = o_s_ready & i_s_valid;
    assign o_mem_data = o_s_ready ? i_s_data : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            idx        <= '0;
            rsum       <= '0;
            o_s_ready  <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_checksum <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        len_q      <= len_clamped;
                        idx        <= '0;
                        rsum       <= '0;
                        o_checksum <= '0;
                        o_err      <= 1'b0;
                        if (len_clamped == '0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            o_s_ready <= 1'b1;
                            o_busy    <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (i_s_valid) begin
                        o_checksum <= o_checksum + i_s_data;
                        if (last) begin
                            idx       <= '0;
                            state     <= VERIFY;
                            o_s_ready <= 1'b0;
                        end else begin
                            idx <= idx + ONE;
                        end
                    end
                end
                VERIFY: begin
                    rsum <= rsum_next;
                    if (last) begin
                        o_err  <= (rsum_next != o_checksum);
                        idx    <= '0;
                        state  <= DONE;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                    end else begin
                        idx <= idx + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - randomized directed bench for ram_loader against a behavioural RAM/checksum model
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [8:0] length;
    logic [7:0] s_data;
    logic       s_valid;

    logic       ready0, ready1, we0, we1, busy0, busy1, done0, done1, err0, err1;
    logic [7:0] addr0, addr1, wdata0, wdata1, rd0, rd1, cks0, cks1;

    logic [7:0] ram0 [256];
    logic [7:0] ram1 [256];
    logic [7:0] wa0[$], wd0[$], wa1[$], wd1[$];
    logic [7:0] tx[$];
    bit         corrupt = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_loader #(.ADDR_W(8), .DATA_W(8), .START_ADDR(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_length(length),
        .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(ready0),
        .o_mem_addr(addr0), .o_mem_data(wdata0), .o_mem_we(we0), .i_mem_data(rd0),
        .o_busy(busy0), .o_done(done0), .o_err(err0), .o_checksum(cks0)
    );

    ram_loader #(.ADDR_W(8), .DATA_W(8), .START_ADDR(8'hFE)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_length(length),
        .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(ready1),
        .o_mem_addr(addr1), .o_mem_data(wdata1), .o_mem_we(we1), .i_mem_data(rd1),
        .o_busy(busy1), .o_done(done1), .o_err(err1), .o_checksum(cks1)
    );

    // Corruption flips the two low bits of location 2 on dut0's read path only (0x33 reads as 0x30)
    assign rd0 = ram0[addr0] ^ ((corrupt && addr0 == 8'd2) ? 8'h03 : 8'h00);
    assign rd1 = ram1[addr1];

    always @(posedge clk) begin
        if (we0) begin
            ram0[addr0] <= wdata0;
            wa0.push_back(addr0);
            wd0.push_back(wdata0);
        end
        if (we1) begin
            ram1[addr1] <= wdata1;
            wa1.push_back(addr1);
            wd1.push_back(wdata1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int n, input int first);
        tx.delete();
        for (int i = 0; i < n; i++)
            tx.push_back((first < 0) ? 8'($urandom) : 8'(first + i));
    endtask

    // Drives one load/verify transaction and compares every observable result against the model
    task automatic run(input string tag, input int len_in, input int stall_at, input int stall_len,
                       input bit rnd_valid, input int ghost_at);
        int n, k, cyc, gaps, stall, sum, bad0, bad1;
        bit v, hs, exp_err;
        n = (len_in > 256) ? 256 : len_in;
        k = 0; gaps = 0; stall = stall_len; sum = 0;
        wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
        start = 1'b1; length = 9'(len_in); s_valid = 1'b0; cyc = 1;
        @(posedge clk); #1;
        start = 1'b0; cyc++;
        for (int t = 0; t < 3000 && !done0; t++) begin
            start  = (t == ghost_at);
            length = (t == ghost_at) ? 9'd7 : 9'(len_in);
            v = 1'b0;
            if (k < n) begin
                if (k == stall_at && stall > 0) stall--;
                else if (rnd_valid && $urandom_range(0, 3) == 0) v = 1'b0;
                else v = 1'b1;
                if (!v) gaps++;
            end
            s_valid = v;
            s_data  = v ? tx[k] : 8'($urandom);
            hs = v && ready0;
            @(posedge clk); #1;
            cyc++;
            if (hs) k++;
        end
        start = 1'b0; s_valid = 1'b0;
        for (int i = 0; i < n; i++) sum += tx[i];
        exp_err = corrupt && n >= 3;
        chk({tag, ".done0"}, 32'(done0), 32'd1);
        chk({tag, ".done1"}, 32'(done1), 32'd1);
        chk({tag, ".latency"}, 32'(cyc), 32'(2 * n + 2 + gaps));
        chk({tag, ".cks0"}, 32'(cks0), 32'(sum & 255));
        chk({tag, ".cks1"}, 32'(cks1), 32'(sum & 255));
        chk({tag, ".err0"}, 32'(err0), 32'(exp_err));
        chk({tag, ".err1"}, 32'(err1), 32'd0);
        chk({tag, ".wcnt0"}, 32'(wa0.size()), 32'(n));
        chk({tag, ".wcnt1"}, 32'(wa1.size()), 32'(n));
        bad0 = 0; bad1 = 0;
        for (int i = 0; i < n && i < wa0.size(); i++)
            if (wa0[i] !== 8'(i) || wd0[i] !== tx[i]) bad0++;
        for (int i = 0; i < n && i < wa1.size(); i++)
            if (wa1[i] !== 8'(254 + i) || wd1[i] !== tx[i]) bad1++;
        chk({tag, ".wseq0"}, 32'(bad0), 32'd0);
        chk({tag, ".wseq1"}, 32'(bad1), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 32'({done0, busy0}), 32'd0);
        chk({tag, ".err_hold"}, 32'(err0), 32'(exp_err));
    endtask

    initial begin
        int dseen;
        rst_n = 1'b0; start = 1'b0; length = '0; s_data = '0; s_valid = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram0[i] = 8'hEE;
            ram1[i] = 8'hEE;
        end
        #1;
        chk("rst.ready", 32'(ready0), 32'd0);
        chk("rst.outs", 32'({we0, busy0, done0, err0}), 32'd0);
        chk("rst.addr0", 32'(addr0), 32'h00);
        chk("rst.addr1", 32'(addr1), 32'hFE);
        chk("rst.cks", 32'(cks0), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        fill(4, 8'h11);
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44;
        run("basic", 4, -1, 0, 1'b0, -1);
        chk("basic.aa", 32'(cks0), 32'hAA);
        run("stall", 4, 2, 3, 1'b0, -1);
        corrupt = 1'b1;
        run("corrupt", 4, -1, 0, 1'b0, -1);
        chk("corrupt.aa", 32'(cks0), 32'hAA);
        corrupt = 1'b0;

        fill(4, 1);
        run("wrap", 4, -1, 0, 1'b0, -1);
        chk("wrap.0a", 32'(cks1), 32'h0A);
        chk("wrap.ram", 32'({ram1[254], ram1[255], ram1[0], ram1[1]}), 32'h01020304);

        tx.delete();
        run("zero", 0, -1, 0, 1'b0, -1);
        chk("zero.cks", 32'(cks0), 32'd0);

        fill(256, -1);
        run("clamp", 300, -1, 0, 1'b0, -1);

        // Reset in the middle of LOAD, with a third byte already presented
        fill(4, 8'h61);
        for (int i = 0; i < 4; i++) ram0[i] = 8'h5A;
        start = 1'b1; length = 9'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = tx[i];
            @(posedge clk); #1;
        end
        s_data = tx[2];
        rst_n = 1'b0;
        #1;
        chk("mid.ready", 32'(ready0), 32'd0);
        chk("mid.outs", 32'({we0, busy0, done0, err0}), 32'd0);
        chk("mid.addr", 32'(addr0), 32'h00);
        chk("mid.wdata", 32'(wdata0), 32'h00);
        chk("mid.cks", 32'(cks0), 32'd0);
        s_valid = 1'b0;
        dseen = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) rst_n = 1'b1;
            @(posedge clk); #1;
            if (done0) dseen++;
        end
        chk("mid.nodone", 32'(dseen), 32'd0);
        chk("mid.ram", 32'({ram0[0], ram0[1], ram0[2], ram0[3]}), 32'h61625A5A);
        run("after_rst", 4, -1, 0, 1'b0, 2);

        for (int r = 0; r < 3; r++) begin
            fill($urandom_range(1, 40), -1);
            run($sformatf("rnd%0d", r), tx.size(), -1, 0, 1'b1, $urandom_range(0, 20));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Write-side initiator for the 8-bit single-port RAM: accepts a byte stream over a valid/ready handshake and writes it to consecutive RAM addresses.
- After loading, reads the same region back through the RAM's combinational read port and checks an 8-bit additive checksum.
- Used to preload program and data memory before the CPU is released from hold.

Parameters:
- ADDR_W, 8, RAM address width; region wraps modulo 2^ADDR_W.
- DATA_W, 8, RAM data width.
- START_ADDR, 0, first RAM address written and verified.

Ports:
- i_clk  in  1  clock; all state changes on posedge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_length  in  ADDR_W+1  byte count, sampled with i_start. 0 is allowed. Values above 2^ADDR_W are clamped to 2^ADDR_W.
- i_s_data  in  DATA_W  stream byte.
- i_s_valid  in  1  stream byte valid.
- o_s_ready  out  1  loader accepts a byte.
- o_mem_addr  out  ADDR_W  RAM address.
- o_mem_data  out  DATA_W  RAM write data.
- o_mem_we  out  1  RAM write enable.
- i_mem_data  in  DATA_W  RAM combinational read data.
- o_busy  out  1  high in LOAD or VERIFY.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  verify checksum mismatch. Valid from o_done until the next accepted start.
- o_checksum  out  DATA_W  sum mod 2^DATA_W of all written bytes.

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE and the index counter to 0.
  - o_s_ready=0, o_mem_we=0, o_mem_data=0, o_mem_addr=START_ADDR.
  - o_busy=0, o_done=0, o_err=0, o_checksum=0, internal read sum=0.
  - Reset mid-LOAD leaves already-written RAM bytes unchanged; there is no rollback.
- Address: o_mem_addr = (START_ADDR + idx) mod 2^ADDR_W in every state, with idx=0 in IDLE/DONE.
- IDLE:
  - When i_start=1, latch the clamped length L and clear o_checksum, the read sum and o_err.
  - If L=0, go to DONE; otherwise go to LOAD.
- LOAD:
  - o_s_ready=1.
  - o_mem_we = i_s_valid and o_mem_data = i_s_data, both combinational, so the RAM captures the byte on the same edge as the handshake.
  - On each handshake (i_s_valid & o_s_ready): o_checksum += i_s_data and idx increments.
  - On the handshake for idx=L-1: idx goes to 0 and the state goes to VERIFY.
  - i_s_valid low means stall: no write and no state change.
- VERIFY:
  - o_s_ready=0, o_mem_we=0.
  - Each cycle: read sum += i_mem_data at the current address, then idx increments.
  - Verify takes exactly L cycles.
  - After the idx=L-1 cycle, o_err is set to (final read sum != o_checksum) and the state goes to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Outside LOAD, o_mem_we=0, o_s_ready=0 and o_mem_data=0.
- i_start is ignored while o_busy=1 or in DONE.
- Latency: with valid held high, o_done occurs 2L+2 cycles after the i_start edge (IDLE→LOAD 1, LOAD L, VERIFY L, DONE pulse).
- Wrap-around:
  - The address wraps modulo 2^ADDR_W.
  - With L=2^ADDR_W, every location is written once and the last address is START_ADDR-1 mod 2^ADDR_W.
- Arithmetic: all sums are modulo 2^DATA_W, with the carry discarded.
- o_checksum holds its value until the next accepted start.

Test Plan:
- Reset, then start with L=4 and stream 0x11,0x22,0x33,0x44 with valid held high → writes at addresses 0..3. Then o_checksum=0xAA, o_done pulses at cycle 10 after start, o_err=0.
- Same as above with valid deasserted for 3 cycles between bytes 2 and 3 → no o_mem_we during the gap, RAM contents identical, o_done delayed by 3 cycles.
- START_ADDR=0xFE, L=4, bytes 0x01..0x04 → writes to 0xFE,0xFF,0x00,0x01. o_checksum=0x0A, o_err=0.
- Bench corrupts the RAM model at address 2 during VERIFY (forces i_mem_data 0x33→0x30) → o_err=1 at o_done, o_checksum=0xAA unchanged.
- L=0 → o_done the cycle after the start edge, no o_mem_we, o_checksum=0. Also: L=300 is clamped to 256, all 256 addresses are written, 256 handshakes occur.
- Reset asserted after 2 of 4 bytes → outputs return to reset values immediately, RAM keeps 2 bytes, o_done never pulses. A subsequent start is accepted normally; i_start pulsed while busy has no effect.
